// File: rtl/xspi_txn_sequencer.sv
// rtl/xspi_txn_sequencer.sv - replays a loaded transaction table to the xSPI controller and checks read data
module xspi_txn_sequencer #(
  parameter int               DEPTH    = 8,
  parameter int               CMD_W    = 8,
  parameter int               ADDR_W   = 48,
  parameter int               DATA_W   = 64,
  parameter int               GAP_W    = 8,
  parameter int               TMO_W    = 12,
  parameter logic [CMD_W-1:0] CMD_READ = 8'hFF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ld_valid,
  output logic                       ld_ready,
  input  logic [CMD_W-1:0]           ld_cmd,
  input  logic [ADDR_W-1:0]          ld_addr,
  input  logic [DATA_W-1:0]          ld_data,
  input  logic [GAP_W-1:0]           ld_gap,
  input  logic                       tbl_clear,
  input  logic                       run,
  input  logic                       loop_en,
  input  logic                       abort,
  output logic                       start,
  output logic [CMD_W-1:0]           command,
  output logic [ADDR_W-1:0]          address,
  output logic [DATA_W-1:0]          wr_data,
  input  logic                       xspi_done,
  input  logic [DATA_W-1:0]          xspi_rd_data,
  output logic                       busy,
  output logic                       seq_done,
  output logic [$clog2(DEPTH)-1:0]   txn_idx,
  output logic [$clog2(DEPTH):0]     tbl_count,
  output logic [15:0]                pass_cnt,
  output logic [15:0]                err_cnt,
  output logic                       tmo_flag
);
  localparam int IW = $clog2(DEPTH);
  localparam logic [IW:0]       DEPTH_C  = (IW+1)'(DEPTH);
  localparam logic [IW:0]       CNT_ONE  = {{IW{1'b0}}, 1'b1};
  localparam logic [IW-1:0]     IDX_ONE  = {{(IW-1){1'b0}}, 1'b1};
  localparam logic [TMO_W-1:0]  TMO_ONE  = {{(TMO_W-1){1'b0}}, 1'b1};
  localparam logic [TMO_W-1:0]  TMO_LAST = {{(TMO_W-1){1'b1}}, 1'b0};
  localparam logic [GAP_W-1:0]  GAP_ONE  = {{(GAP_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_GAP} state_t;

  state_t              state_q, state_d;
  logic                rdy_q, rdy_d;
  logic [IW:0]         cnt_q, cnt_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [CMD_W-1:0]    cmd_q, cmd_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdat_q, wdat_d;
  logic [GAP_W-1:0]    gap_q, gap_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic [15:0]         pass_q, pass_d, err_q, err_d;
  logic                tmof_q, tmof_d, sdone_q, sdone_d;
  logic                ld_we, go_issue;
  logic [IW-1:0]       iss_idx;

  // Table storage carries no reset; tbl_count alone defines which entries are valid.
  logic [CMD_W-1:0]    tbl_cmd  [DEPTH];
  logic [ADDR_W-1:0]   tbl_addr [DEPTH];
  logic [DATA_W-1:0]   tbl_data [DEPTH];
  logic [GAP_W-1:0]    tbl_gap  [DEPTH];

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign ld_ready  = rdy_q && (state_q == S_IDLE) && (cnt_q < DEPTH_C);
  assign start     = (state_q == S_ISSUE) && !abort;
  assign busy      = (state_q != S_IDLE);
  assign command   = cmd_q;
  assign address   = addr_q;
  assign wr_data   = wdat_q;
  assign seq_done  = sdone_q;
  assign txn_idx   = idx_q;
  assign tbl_count = cnt_q;
  assign pass_cnt  = pass_q;
  assign err_cnt   = err_q;
  assign tmo_flag  = tmof_q;

  always_comb begin
    state_d  = state_q;
    rdy_d    = 1'b1;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    cmd_d    = cmd_q;
    addr_d   = addr_q;
    wdat_d   = wdat_q;
    gap_d    = gap_q;
    tmo_d    = tmo_q;
    pass_d   = pass_q;
    err_d    = err_q;
    tmof_d   = tmof_q;
    sdone_d  = 1'b0;
    ld_we    = 1'b0;
    go_issue = 1'b0;
    iss_idx  = idx_q;
    case (state_q)
      S_IDLE: begin
        if (tbl_clear) begin
          cnt_d = '0;
        end else begin
          if (ld_valid && ld_ready) begin
            ld_we = 1'b1;
            cnt_d = cnt_q + CNT_ONE;
          end
          if (run && (cnt_q != '0)) begin
            go_issue = 1'b1;
            iss_idx  = '0;
            pass_d   = '0;
            err_d    = '0;
            tmof_d   = 1'b0;
          end
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
        tmo_d   = '0;
      end
      S_WAIT: begin
        if (xspi_done) begin
          if (cmd_q == CMD_READ) begin
            if (xspi_rd_data == tbl_data[idx_q]) pass_d = sat_inc(pass_q);
            else                                 err_d  = sat_inc(err_q);
          end
          state_d = S_GAP;
          gap_d   = tbl_gap[idx_q];
        end else if (tmo_q == TMO_LAST) begin
          // The counter reaches all-ones on this edge: 2**TMO_W-1 WAIT cycles elapsed.
          err_d   = sat_inc(err_q);
          tmof_d  = 1'b1;
          tmo_d   = tmo_q + TMO_ONE;
          state_d = S_GAP;
          gap_d   = tbl_gap[idx_q];
        end else begin
          tmo_d = tmo_q + TMO_ONE;
        end
      end
      S_GAP: begin
        if (gap_q != '0) begin
          gap_d = gap_q - GAP_ONE;
        end else if (({1'b0, idx_q} + CNT_ONE) < cnt_q) begin
          go_issue = 1'b1;
          iss_idx  = idx_q + IDX_ONE;
        end else if (loop_en) begin
          go_issue = 1'b1;
          iss_idx  = '0;
        end else begin
          state_d = S_IDLE;
          sdone_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (go_issue) begin
      state_d = S_ISSUE;
      idx_d   = iss_idx;
      cmd_d   = tbl_cmd[iss_idx];
      addr_d  = tbl_addr[iss_idx];
      wdat_d  = (tbl_cmd[iss_idx] == CMD_READ) ? '0 : tbl_data[iss_idx];
    end
    // Abort freezes all replay state; only table loading/clearing in IDLE proceeds.
    if (abort) begin
      state_d = S_IDLE;
      idx_d   = idx_q;
      cmd_d   = cmd_q;
      addr_d  = addr_q;
      wdat_d  = wdat_q;
      gap_d   = gap_q;
      tmo_d   = tmo_q;
      pass_d  = pass_q;
      err_d   = err_q;
      tmof_d  = tmof_q;
      sdone_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      rdy_q   <= 1'b0;
      cnt_q   <= '0;
      idx_q   <= '0;
      cmd_q   <= '0;
      addr_q  <= '0;
      wdat_q  <= '0;
      gap_q   <= '0;
      tmo_q   <= '0;
      pass_q  <= '0;
      err_q   <= '0;
      tmof_q  <= 1'b0;
      sdone_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rdy_q   <= rdy_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      cmd_q   <= cmd_d;
      addr_q  <= addr_d;
      wdat_q  <= wdat_d;
      gap_q   <= gap_d;
      tmo_q   <= tmo_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      tmof_q  <= tmof_d;
      sdone_q <= sdone_d;
    end
  end

  always_ff @(posedge clk) begin
    if (ld_we) begin
      tbl_cmd[cnt_q[IW-1:0]]  <= ld_cmd;
      tbl_addr[cnt_q[IW-1:0]] <= ld_addr;
      tbl_data[cnt_q[IW-1:0]] <= ld_data;
      tbl_gap[cnt_q[IW-1:0]]  <= ld_gap;
    end
  end
endmodule

// File: tb/tb_xspi_txn_sequencer.sv
// tb/tb_xspi_txn_sequencer.sv - scoreboard bench for xspi_txn_sequencer
module tb_xspi_txn_sequencer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ld_valid = 1'b0, ld_ready;
  logic [7:0]  ld_cmd = '0;
  logic [47:0] ld_addr = '0;
  logic [63:0] ld_data = '0;
  logic [7:0]  ld_gap = '0;
  logic        tbl_clear = 1'b0, run = 1'b0, loop_en = 1'b0, abort = 1'b0;
  logic        start;
  logic [7:0]  command;
  logic [47:0] address;
  logic [63:0] wr_data;
  logic        xspi_done = 1'b0;
  logic [63:0] xspi_rd_data = '0;
  logic        busy, seq_done, tmo_flag;
  logic [2:0]  txn_idx;
  logic [3:0]  tbl_count;
  logic [15:0] pass_cnt, err_cnt;

  xspi_txn_sequencer dut (
    .clk(clk), .rst(rst), .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_cmd(ld_cmd),
    .ld_addr(ld_addr), .ld_data(ld_data), .ld_gap(ld_gap), .tbl_clear(tbl_clear),
    .run(run), .loop_en(loop_en), .abort(abort), .start(start), .command(command),
    .address(address), .wr_data(wr_data), .xspi_done(xspi_done),
    .xspi_rd_data(xspi_rd_data), .busy(busy), .seq_done(seq_done), .txn_idx(txn_idx),
    .tbl_count(tbl_count), .pass_cnt(pass_cnt), .err_cnt(err_cnt), .tmo_flag(tmo_flag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  cmd;
    logic [47:0] addr;
    logic [63:0] wd;
    int          idx;
    int          space;
  } exp_t;

  exp_t        exp_q[$];
  int          n_cmp = 0, n_fail = 0;
  int          cyc = 0, last_start = 0, n_starts = 0, n_sdone = 0, sdone_cyc = 0;
  bit          resp_en = 1'b0;
  logic [63:0] rd_resp = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  function automatic exp_t mk(input logic [7:0] c, input logic [47:0] a, input logic [63:0] w,
                              input int i, input int s);
    exp_t e;
    e.cmd = c; e.addr = a; e.wd = w; e.idx = i; e.space = s;
    return e;
  endfunction

  // Monitor: every start pulse is matched against the next expected issue.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (start === 1'b1) begin
        n_starts++;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_start: got cmd %0h idx %0d expected no start", command, txn_idx);
        end else begin
          e = exp_q.pop_front();
          chk("start_cmd", 64'(command), 64'(e.cmd));
          chk("start_addr", 64'(address), 64'(e.addr));
          chk("start_wr_data", wr_data, e.wd);
          chk("start_idx", 64'(txn_idx), 64'(e.idx));
          if (e.space > 0) chk("start_spacing", 64'(cyc - last_start), 64'(e.space));
        end
        last_start = cyc;
      end
      if (seq_done === 1'b1) begin
        n_sdone++;
        sdone_cyc = cyc;
      end
    end
  end

  // Controller model: completes each transaction in its first WAIT cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (start === 1'b1 && resp_en) begin
        @(negedge clk);
        xspi_done    = 1'b1;
        xspi_rd_data = rd_resp;
        @(negedge clk);
        xspi_done    = 1'b0;
        xspi_rd_data = '0;
      end
    end
  end

  task automatic load(input logic [7:0] c, input logic [47:0] a, input logic [63:0] d,
                      input logic [7:0] g, output logic rdy);
    @(negedge clk);
    ld_valid = 1'b1; ld_cmd = c; ld_addr = a; ld_data = d; ld_gap = g;
    rdy = ld_ready;
    @(negedge clk);
    ld_valid = 1'b0;
  endtask

  task automatic pulse_run();
    @(negedge clk); run = 1'b1;
    @(negedge clk); run = 1'b0;
  endtask

  task automatic clear_tbl();
    @(negedge clk); tbl_clear = 1'b1;
    @(negedge clk); tbl_clear = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string nm);
    int n = 0;
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(nm, 64'(busy), 64'd0);
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic r;
    int   sd0, st0, n;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_ld_ready", 64'(ld_ready), 0);
    chk("rst_tbl_count", 64'(tbl_count), 0);
    chk("rst_outputs", 64'({start, seq_done, tmo_flag, pass_cnt, err_cnt, command}), 0);
    rst = 1'b0;
    #1 chk("ld_ready_before_clk", 64'(ld_ready), 0);
    @(negedge clk);
    chk("ld_ready_after_clk", 64'(ld_ready), 1);

    // 1: write then read, matching data
    load(8'hA5, 48'h6655443322AB, 64'h1122334455667788, 8'd0, r);
    load(8'hFF, 48'h6655443322AB, 64'h1122334455667788, 8'd4, r);
    chk("t1_count", 64'(tbl_count), 2);
    resp_en = 1'b1;
    rd_resp = 64'h1122334455667788;
    exp_q.push_back(mk(8'hA5, 48'h6655443322AB, 64'h1122334455667788, 0, 0));
    exp_q.push_back(mk(8'hFF, 48'h6655443322AB, 64'h0, 1, 3));
    sd0 = n_sdone;
    pulse_run();
    wait_idle(100, "t1_idle");
    chk("t1_pass", 64'(pass_cnt), 1);
    chk("t1_err", 64'(err_cnt), 0);
    chk("t1_seq_done", 64'(n_sdone - sd0), 1);
    chk("t1_queue_drained", 64'(exp_q.size()), 0);

    // 2: mismatching read data
    rd_resp = 64'h1122334455667789;
    exp_q.push_back(mk(8'hA5, 48'h6655443322AB, 64'h1122334455667788, 0, 0));
    exp_q.push_back(mk(8'hFF, 48'h6655443322AB, 64'h0, 1, 3));
    pulse_run();
    wait_idle(100, "t2_idle");
    chk("t2_pass", 64'(pass_cnt), 0);
    chk("t2_err", 64'(err_cnt), 1);
    chk("t2_tmo", 64'(tmo_flag), 0);

    // 3: controller never completes -> timeout
    clear_tbl();
    load(8'hFF, 48'h000000001000, 64'hDEADBEEFCAFEF00D, 8'd2, r);
    resp_en = 1'b0;
    exp_q.push_back(mk(8'hFF, 48'h000000001000, 64'h0, 0, 0));
    sd0 = n_sdone;
    st0 = n_starts;
    pulse_run();
    wait_idle(5000, "t3_idle");
    chk("t3_err", 64'(err_cnt), 1);
    chk("t3_pass", 64'(pass_cnt), 0);
    chk("t3_tmo_flag", 64'(tmo_flag), 1);
    chk("t3_seq_done", 64'(n_sdone - sd0), 1);
    chk("t3_one_start", 64'(n_starts - st0), 1);
    chk("t3_latency", 64'(sdone_cyc - last_start), 4099);

    // 4: loop mode, three passes, abort in GAP after the last read
    clear_tbl();
    load(8'h01, 48'h000000000010, 64'h000000000000AAAA, 8'd1, r);
    load(8'hFF, 48'h000000000020, 64'h0000000000005555, 8'd0, r);
    resp_en = 1'b1;
    rd_resp = 64'h5555;
    loop_en = 1'b1;
    for (int p = 0; p < 3; p++) begin
      exp_q.push_back(mk(8'h01, 48'h10, 64'hAAAA, 0, (p == 0) ? 0 : 3));
      exp_q.push_back(mk(8'hFF, 48'h20, 64'h0, 1, 4));
    end
    sd0 = n_sdone;
    pulse_run();
    n = 0;
    while (pass_cnt != 16'd3 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("t4_three_passes", 64'(pass_cnt), 3);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("t4_idle_after_abort", 64'(busy), 0);
    repeat (10) @(negedge clk);
    loop_en = 1'b0;
    chk("t4_no_seq_done", 64'(n_sdone - sd0), 0);
    chk("t4_err", 64'(err_cnt), 0);
    chk("t4_tmo_cleared", 64'(tmo_flag), 0);
    chk("t4_idx_held", 64'(txn_idx), 1);
    chk("t4_queue_drained", 64'(exp_q.size()), 0);

    // 5: fill past DEPTH, clear priority, run on empty table
    clear_tbl();
    chk("t5_cleared", 64'(tbl_count), 0);
    for (int i = 0; i < 9; i++) begin
      load(8'(i), 48'(i), 64'(i), 8'd0, r);
      chk("t5_ld_ready", 64'(r), (i < 8) ? 64'd1 : 64'd0);
    end
    chk("t5_full_count", 64'(tbl_count), 8);
    clear_tbl();
    chk("t5_clear_count", 64'(tbl_count), 0);
    load(8'h11, 48'h1, 64'h1, 8'd0, r);
    @(negedge clk);
    tbl_clear = 1'b1; ld_valid = 1'b1;
    @(negedge clk);
    tbl_clear = 1'b0; ld_valid = 1'b0;
    chk("t5_clear_beats_load", 64'(tbl_count), 0);
    pulse_run();
    repeat (3) @(negedge clk);
    chk("t5_run_empty", 64'(busy), 0);

    // 6: async reset during WAIT
    resp_en = 1'b0;
    load(8'hFF, 48'h123456789ABC, 64'h0, 8'd0, r);
    exp_q.push_back(mk(8'hFF, 48'h123456789ABC, 64'h0, 0, 0));
    pulse_run();
    repeat (4) @(negedge clk);
    chk("t6_busy_in_wait", 64'(busy), 1);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_busy", 64'(busy), 0);
    chk("t6_rst_cmd_addr", 64'(command) | 64'(address), 0);
    chk("t6_rst_count", 64'(tbl_count), 0);
    chk("t6_rst_misc", 64'({start, ld_ready, seq_done, tmo_flag, txn_idx}), 0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("t6_ld_ready_held", 64'(ld_ready), 0);
    pulse_run();
    repeat (3) @(negedge clk);
    chk("t6_run_empty", 64'(busy), 0);
    chk("t6_queue_drained", 64'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
